stream_producer: RTL and testbench



---
 rtl/stream_producer_pkg.sv | 15 +
 rtl/stream_producer_gap.sv | 34 +++
 rtl/stream_producer.sv | 146 ++++++++++++++
 tb/tb_stream_producer.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/stream_producer_pkg.sv
// Shared definitions for the val/data stream producer: default widths and FSM states.
package stream_producer_pkg;

  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned GAP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/stream_producer_gap.sv
// Loadable down-counter that times the idle gap between words.
module gap_timer #(
  parameter int unsigned GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expired_o
);

  logic [GAP_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/stream_producer.sv
// Transmit end of the val/data interface: emits an arithmetic word sequence
// with backpressure, optional inter-word gaps and a running modular sum.
module stream_producer
  import stream_producer_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned GAP_W = GAP_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [CNT_W-1:0] len,
  input  logic [WIDTH-1:0] first,
  input  logic [WIDTH-1:0] step,
  input  logic [GAP_W-1:0] gap,
  input  logic             rdy,
  output logic             val,
  output logic [WIDTH-1:0] data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sent_sum
);

  state_e           state_q, state_d;
  logic             val_q, val_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             tmr_load;
  logic             tmr_expired;

  // Timer is loaded with gap-1 so that expiry lands on the last idle cycle.
  gap_timer #(.GAP_W(GAP_W)) u_gap_timer (
    .clk        (clk),
    .rst_b      (rst_b),
    .load_i     (tmr_load),
    .load_val_i (gap_q - GAP_W'(1)),
    .dec_i      (state_q == ST_GAP),
    .expired_o  (tmr_expired)
  );

  always_comb begin
    state_d  = state_q;
    val_d    = val_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    rem_d    = rem_q;
    step_d   = step_q;
    gap_d    = gap_q;
    tmr_load = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          step_d = step;
          gap_d  = gap;
          sum_d  = '0;
          rem_d  = len;
          if (len != '0) begin
            state_d = ST_SEND;
            val_d   = 1'b1;
            data_d  = first;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
      end

      ST_SEND: begin
        if (rdy) begin
          sum_d = sum_q + data_q;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_DONE;
            val_d   = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (gap_q == '0) begin
            data_d = data_q + step_q;
          end else begin
            state_d  = ST_GAP;
            val_d    = 1'b0;
            tmr_load = 1'b1;
          end
        end
      end

      ST_GAP: begin
        if (tmr_expired) begin
          state_d = ST_SEND;
          val_d   = 1'b1;
          data_d  = data_q + step_q;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= ST_IDLE;
      val_q   <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      rem_q   <= '0;
      step_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      step_q  <= step_d;
      gap_q   <= gap_d;
    end
  end

  assign val      = val_q;
  assign data     = data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sent_sum = sum_q;

endmodule

// File: tb/tb_stream_producer.sv
// Randomized bench for stream_producer against a transaction-level word/sum model.
module tb_stream_producer;

  localparam int unsigned W     = 8;
  localparam int unsigned CW    = 8;
  localparam int unsigned GW    = 4;
  localparam int unsigned LIMIT = 3000;

  logic          clk   = 1'b0;
  logic          rst_b = 1'b0;
  logic          start = 1'b0;
  logic          rdy   = 1'b0;
  logic [CW-1:0] len   = '0;
  logic [W-1:0]  first = '0;
  logic [W-1:0]  step  = '0;
  logic [GW-1:0] gap   = '0;
  logic          val, busy, done;
  logic [W-1:0]  data, sent_sum;

  int n_tests = 0;
  int n_fail  = 0;

  stream_producer #(.WIDTH(W), .CNT_W(CW), .GAP_W(GW)) dut (
    .clk      (clk),
    .rst_b    (rst_b),
    .start    (start),
    .len      (len),
    .first    (first),
    .step     (step),
    .gap      (gap),
    .rdy      (rdy),
    .val      (val),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .sent_sum (sent_sum)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic scramble();
    len   = CW'($urandom);
    first = W'($urandom);
    step  = W'($urandom);
    gap   = GW'($urandom);
  endtask

  // Expected words come from a queue; the final sum from the closed-form series sum.
  task automatic run_seq(input string nm, input logic [W-1:0] f, input logic [W-1:0] s,
                         input logic [CW-1:0] n, input logic [GW-1:0] g,
                         input int unsigned pct, input int unsigned st_lo,
                         input int unsigned st_hi, input bit poke);
    logic [W-1:0] words[$];
    logic [W-1:0] w, part, total;
    int unsigned  idx, quiet, cyc;
    bit           exp_val;
    int           ni;
    w = f;
    for (int i = 0; i < int'(n); i++) begin
      words.push_back(w);
      w = w + s;
    end
    ni    = int'(n);
    total = W'((int'(f) * ni + int'(s) * ((ni * (ni - 1)) / 2)) % (1 << W));

    start = 1'b1; first = f; step = s; len = n; gap = g; rdy = 1'($urandom);
    @(negedge clk);
    start = 1'b0;
    scramble();

    if (n == '0) begin
      check_eq({nm, ".len0_done"}, done, 1);
      check_eq({nm, ".len0_val"}, val, 0);
      check_eq({nm, ".len0_busy"}, busy, 0);
      check_eq({nm, ".len0_sum"}, sent_sum, 0);
      @(negedge clk);
      check_eq({nm, ".len0_done_clr"}, done, 0);
      return;
    end

    idx = 0; quiet = 0; cyc = 1; part = '0;
    while (idx < int'(n) && cyc <= LIMIT) begin
      exp_val = (quiet == 0);
      check_eq({nm, ".val"}, val, exp_val);
      check_eq({nm, ".busy"}, busy, 1);
      check_eq({nm, ".done_early"}, done, 0);
      check_eq({nm, ".sum_run"}, sent_sum, part);
      if (exp_val) check_eq({nm, ".data"}, data, words[idx]);
      if (cyc >= st_lo && cyc <= st_hi) rdy = 1'b0;
      else rdy = ($urandom_range(99) < pct);
      start = poke && (cyc == 2);
      @(negedge clk);
      start = 1'b0;
      scramble();
      if (exp_val && rdy) begin
        part  = part + words[idx];
        idx++;
        quiet = (idx < int'(n)) ? int'(g) : 0;
      end else if (!exp_val) begin
        quiet--;
      end
      cyc++;
    end

    check_eq({nm, ".all_sent"}, idx, n);
    check_eq({nm, ".done"}, done, 1);
    check_eq({nm, ".done_val"}, val, 0);
    check_eq({nm, ".done_busy"}, busy, 0);
    check_eq({nm, ".sum_final"}, sent_sum, total);
    @(negedge clk);
    check_eq({nm, ".done_clr"}, done, 0);
    check_eq({nm, ".sum_hold"}, sent_sum, total);
    check_eq({nm, ".idle_val"}, val, 0);
  endtask

  initial begin
    rst_b = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst.val", val, 0);
    check_eq("rst.data", data, 0);
    check_eq("rst.busy", busy, 0);
    check_eq("rst.done", done, 0);
    check_eq("rst.sum", sent_sum, 0);
    rst_b = 1'b1;

    run_seq("basic", 8'd3, 8'd2, 8'd4, 4'd0, 100, 0, 0, 1'b0);
    run_seq("bp", 8'd3, 8'd2, 8'd4, 4'd0, 100, 2, 4, 1'b0);
    run_seq("gap", 8'd10, 8'd1, 8'd3, 4'd2, 100, 0, 0, 1'b0);
    run_seq("wrap", 8'd250, 8'd5, 8'd3, 4'd0, 100, 0, 0, 1'b0);
    run_seq("len0", 8'h55, 8'd1, 8'd0, 4'd3, 100, 0, 0, 1'b0);
    run_seq("step0", 8'd77, 8'd0, 8'd5, 4'd1, 70, 0, 0, 1'b0);
    run_seq("busy_start", 8'd7, 8'd3, 8'd6, 4'd1, 100, 0, 0, 1'b1);

    // Reset during the second word of a len=5 run.
    start = 1'b1; first = 8'd20; step = 8'd4; len = 8'd5; gap = 4'd0; rdy = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq("mid.w0", data, 20);
    @(negedge clk);
    check_eq("mid.w1_val", val, 1);
    check_eq("mid.w1", data, 24);
    rst_b = 1'b0;
    @(negedge clk);
    rst_b = 1'b1;
    check_eq("mid.val", val, 0);
    check_eq("mid.busy", busy, 0);
    check_eq("mid.sum", sent_sum, 0);
    check_eq("mid.done", done, 0);
    @(negedge clk);
    check_eq("mid.no_done", done, 0);
    check_eq("mid.idle_val", val, 0);
    run_seq("after_rst", 8'd20, 8'd4, 8'd5, 4'd0, 100, 0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      run_seq("rnd", W'($urandom), W'($urandom), CW'($urandom_range(0, 12)),
              GW'($urandom_range(0, 3)), $urandom_range(30, 100), 0, 0,
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
